// File: rtl/seq_det_sched.sv
// Multi-channel run-of-ones detector: a round-robin arbiter grants one serial
// channel per cycle, and a single shared datapath updates that channel's
// private run counter and reports the outcome one cycle later.
module seq_det_sched #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned RUN_LEN = 3,
  localparam int unsigned CHW    = $clog2(NCH),
  localparam int unsigned CW     = $clog2(RUN_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH-1:0] in_bit,
  input  logic [NCH-1:0] clr_ch,
  output logic [NCH-1:0] in_ready,
  output logic           det_valid,
  output logic [CHW-1:0] det_ch,
  output logic           det_hit,
  output logic [7:0]     hit_total
);

  logic [CW-1:0]  r_cnt [NCH];
  logic [CHW-1:0] r_rr;
  logic           r_det_valid;
  logic [CHW-1:0] r_det_ch;
  logic           r_det_hit;
  logic [7:0]     r_total;

  logic [NCH-1:0] w_elig;
  logic           w_found;
  logic [CHW-1:0] w_gidx;
  logic [CHW-1:0] w_idx;
  logic           w_xfer;
  logic [CW-1:0]  w_cur;
  logic [CW-1:0]  w_new;
  logic           w_hit;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    w_elig  = in_valid & ~clr_ch;
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_idx = r_rr + CHW'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    w_xfer   = w_found & ~rst;
    in_ready = '0;
    in_ready[w_gidx] = w_xfer;
  end

  // Shared counter update for the granted channel; a completed run wraps to 1
  always_comb begin
    w_cur = r_cnt[w_gidx];
    w_new = '0;
    if (in_bit[w_gidx]) begin
      if (w_cur == CW'(RUN_LEN)) w_new = CW'(1);
      else                       w_new = w_cur + CW'(1);
    end
    w_hit = (w_new == CW'(RUN_LEN));
  end

  // Per-channel contexts, arbitration pointer, result registers and hit count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) r_cnt[c] <= '0;
      r_rr        <= CHW'(NCH - 1);
      r_det_valid <= 1'b0;
      r_det_ch    <= '0;
      r_det_hit   <= 1'b0;
      r_total     <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (clr_ch[c])                              r_cnt[c] <= '0;
        else if (w_xfer && (w_gidx == CHW'(c)))     r_cnt[c] <= w_new;
      end
      r_det_valid <= w_xfer;
      r_det_hit   <= w_xfer & w_hit;
      if (w_xfer) begin
        r_rr     <= w_gidx;
        r_det_ch <= w_gidx;
        if (w_hit && (r_total != 8'hFF)) r_total <= r_total + 8'd1;
      end
    end
  end

  assign det_valid = r_det_valid;
  assign det_ch    = r_det_ch;
  assign det_hit   = r_det_hit;
  assign hit_total = r_total;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched (NCH=4, RUN_LEN=3): vector table of per-cycle
// stimulus with hand-derived grants and hits, plus long saturation and
// mid-run reset sequences. Expected reports are queued when a cycle is
// driven and compared when the DUT presents them the next cycle.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid, in_bit, clr_ch, in_ready;
  logic       det_valid, det_hit;
  logic [1:0] det_ch;
  logic [7:0] hit_total;

  seq_det_sched #(.NCH(4), .RUN_LEN(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clr_ch(clr_ch), .in_ready(in_ready), .det_valid(det_valid),
    .det_ch(det_ch), .det_hit(det_hit), .hit_total(hit_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] v, b, c, rdy;
    logic       h;
  } vec_t;

  typedef struct {
    logic       dv;
    logic [1:0] ch;
    logic       hit;
    int         total;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step     = 0;
  int   exp_total = 0;
  logic [1:0] last_ch = '0;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL step %0d %s got %0d want %0d", step, nm, act, req);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] rdy, input logic h);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.c = c; t.rdy = rdy; t.h = h;
    vecs.push_back(t);
  endtask

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] ix = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) ix = 2'(i);
    return ix;
  endfunction

  // One clock cycle: drive, check grant, queue expected report, compare it
  task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] rdy, input logic h);
    exp_t e, got;
    rst = r; in_valid = v; in_bit = b; clr_ch = c;
    #1;
    chk("in_ready", int'(in_ready), int'(rdy));
    if (r) begin
      e.dv = 1'b0; e.ch = '0; e.hit = 1'b0; exp_total = 0; last_ch = '0;
    end else if (rdy != 4'd0) begin
      e.dv = 1'b1; e.ch = oh_idx(rdy); e.hit = h; last_ch = e.ch;
      if (h && exp_total < 255) exp_total++;
    end else begin
      e.dv = 1'b0; e.ch = last_ch; e.hit = 1'b0;
    end
    e.total = exp_total;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL step %0d scoreboard empty got 0 want 1", step);
    end else begin
      got = sb.pop_front();
      chk("det_valid", int'(det_valid), int'(got.dv));
      chk("det_ch",    int'(det_ch),    int'(got.ch));
      chk("det_hit",   int'(det_hit),   int'(got.hit));
      chk("hit_total", int'(hit_total), got.total);
    end
    step++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_bit = '0; clr_ch = '0;

    // ch0 only, six ones: hits on 3rd and 6th
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 1);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 1);
    // ch0 1,1,0,1,1,1 (cnt 3 wraps to 1 first): single hit on 6th
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h0, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'h1, 1);
    // idle: no grant, det_ch holds
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    // reset with all valid: no grant; then round-robin 0,1,2,3,0,1
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h1, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h2, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h4, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h8, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h1, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h2, 0);
    // ch1 run interleaved with ch2 traffic keeps its context
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'h6, 4'h6, 4'h0, 4'h2, 0);
    add(0, 4'h6, 4'h6, 4'h0, 4'h4, 0);
    add(0, 4'h6, 4'h6, 4'h0, 4'h2, 0);
    add(0, 4'h4, 4'h0, 4'h0, 4'h4, 0);
    add(0, 4'h2, 4'h2, 4'h0, 4'h2, 1);
    // ch3 reaches cnt 2, clear blocks grant, run restarts from 0
    add(0, 4'h8, 4'h8, 4'h0, 4'h8, 0);
    add(0, 4'h8, 4'h8, 4'h0, 4'h8, 0);
    add(0, 4'h8, 4'h8, 4'h8, 4'h0, 0);
    add(0, 4'h8, 4'h8, 4'h0, 4'h8, 0);
    add(0, 4'h8, 4'h8, 4'h0, 4'h8, 0);
    add(0, 4'h8, 4'h8, 4'h0, 4'h8, 1);
    // ch0/ch1 cleared together while ch2 is granted
    add(0, 4'h3, 4'h3, 4'h0, 4'h1, 0);
    add(0, 4'h3, 4'h3, 4'h0, 4'h2, 0);
    add(0, 4'h4, 4'h0, 4'h3, 4'h4, 0);
    add(0, 4'h3, 4'h3, 4'h0, 4'h1, 0);
    add(0, 4'h3, 4'h3, 4'h0, 4'h2, 0);
    add(0, 4'h3, 4'h3, 4'h0, 4'h1, 0);
    add(0, 4'h3, 4'h3, 4'h0, 4'h2, 0);
    add(0, 4'h3, 4'h3, 4'h0, 4'h1, 1);
    add(0, 4'h3, 4'h3, 4'h0, 4'h2, 1);

    @(negedge clk);
    foreach (vecs[i])
      cyc(vecs[i].r, vecs[i].v, vecs[i].b, vecs[i].c, vecs[i].rdy, vecs[i].h);

    // 260 hits on ch0: hit_total saturates at 255
    cyc(1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 780; i++)
      cyc(0, 4'h1, 4'h1, 4'h0, 4'h1, (i % 3) == 2);

    // partial run on ch0, reset mid-run, run restarts from zero
    cyc(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    cyc(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    cyc(1, 4'h1, 4'h1, 4'h1, 4'h0, 0);
    cyc(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    cyc(0, 4'h1, 4'h1, 4'h0, 4'h1, 0);
    cyc(0, 4'h1, 4'h1, 4'h0, 4'h1, 1);

    if (sb.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
